// File: rtl/chi_link_rx_pkg.sv
// Shared CHI link-layer types: flit layouts, opcodes and the credit limit of one channel.
package chi_link_rx_pkg;

  localparam int CHI_MAX_LCRD = 15;
  localparam int CRD_W        = $clog2(CHI_MAX_LCRD + 1);

  typedef logic [6:0] chi_opcode_t;

  // Opcode 0 is the link-credit return on every channel type.
  localparam chi_opcode_t LCRD_RETURN_OPC = '0;

  typedef enum logic [6:0] {
    REQ_LCRD_RETURN = 7'h00,
    READ_SHARED     = 7'h01,
    READ_CLEAN      = 7'h02,
    READ_ONCE       = 7'h03,
    READ_UNIQUE     = 7'h07
  } req_opcode_t;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [11:0] txn_id;
    chi_opcode_t opcode;
    logic [47:0] addr;
  } request_flit_t;

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [11:0] txn_id;
    chi_opcode_t opcode;
    logic [2:0]  resp;
    logic [11:0] dbid;
  } response_flit_t;

  typedef struct packed {
    logic [6:0]  src_id;
    logic [11:0] txn_id;
    logic [6:0]  fwd_nid;
    chi_opcode_t opcode;
    logic [44:0] addr;
  } snoop_flit_t;

  typedef struct packed {
    logic [11:0]  txn_id;
    chi_opcode_t  opcode;
    logic [11:0]  dbid;
    logic [1:0]   data_id;
    logic [31:0]  be;
    logic [255:0] data;
  } data_flit_t;

  function automatic logic is_lcrd_return(input chi_opcode_t opc);
    return opc == LCRD_RETURN_OPC;
  endfunction

endpackage

// File: rtl/chi_link_rx_if.sv
// One CHI channel between a flit transmitter and receiver; lcrd_v flows back to the transmitter.
interface chi_link_rx_if import chi_link_rx_pkg::*; #(
  parameter type DATA_T = request_flit_t
) ();

  logic  flit_pend;
  logic  flit_v;
  DATA_T flit;
  logic  lcrd_v;

  modport master (output flit_pend, flit_v, flit, input lcrd_v);
  modport slave  (input flit_pend, flit_v, flit, output lcrd_v);
  modport tx     (output flit_pend, flit_v, flit, input lcrd_v);
  modport rx     (input flit_pend, flit_v, flit, output lcrd_v);

endinterface

// File: rtl/chi_link_rx_flit_fifo.sv
// Synchronous first-word-fall-through flit FIFO; written flit is at head one edge after push.
// No backpressure port: the credit scheme upstream guarantees a push never finds it full.
module chi_link_rx_flit_fifo import chi_link_rx_pkg::*; #(
  parameter type DATA_T = request_flit_t,
  parameter int  DEPTH  = 4,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  DATA_T         push_dat,
  input  logic          pop,
  output DATA_T         head,
  output logic [CW-1:0] count
);

  DATA_T         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= nxt(wr_ptr);
      if (pop_ok)  rd_ptr <= nxt(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/chi_link_rx.sv
// CHI link receiver: grants L-credits, buffers credited flits, presents them FWFT; one-edge enqueue latency.
// Backpressure is by credit only: out_ready low holds the FIFO, which withholds new credits.
module chi_link_rx import chi_link_rx_pkg::*; #(
  parameter type DATA_T = request_flit_t,
  parameter int  DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  chi_link_rx_if.rx        rx,
  input  logic             link_en,
  output logic             out_valid,
  input  logic             out_ready,
  output DATA_T            out_flit,
  output logic [CRD_W-1:0] credits_out,
  output logic             credits_idle,
  output logic             proto_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CRD_W + 1;

  logic [CW-1:0] count;
  logic [OW-1:0] occupied;
  logic          credited;
  logic          push;
  logic          ret;
  logic          pop;
  logic          grant;
  logic          lcrd_q;
  logic          unused_pend;

  assign unused_pend = rx.flit_pend;

  // A flit only consumes a credit if one is outstanding; otherwise it is a protocol error.
  assign credited = rx.flit_v && (credits_out != '0);
  assign ret      = credited && is_lcrd_return(rx.flit.opcode);
  assign push     = credited && !ret;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Buffered flits plus credits in flight never exceed the FIFO depth.
  assign occupied = OW'(count) + OW'(credits_out);
  assign grant    = link_en && (occupied < OW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_out <= '0;
      lcrd_q      <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      credits_out <= credits_out + CRD_W'(grant) - CRD_W'(credited);
      lcrd_q      <= grant;
      proto_err   <= proto_err | (rx.flit_v && (credits_out == '0));
    end
  end

  assign rx.lcrd_v    = lcrd_q;
  assign credits_idle = (credits_out == '0);

  chi_link_rx_flit_fifo #(
    .DATA_T (DATA_T),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (rx.flit),
    .pop      (pop),
    .head     (out_flit),
    .count    (count)
  );

endmodule

// File: tb/tb_chi_link_rx.sv
// Bench for chi_link_rx: a DEPTH=4 instance for credit/error/reset scenarios and a DEPTH=3 one for wrap.
module tb_chi_link_rx;
  import chi_link_rx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          link_en4, out_valid4, out_ready4, credits_idle4, proto_err4;
  request_flit_t out_flit4;
  logic [3:0]    credits_out4;
  logic          link_en3, out_valid3, out_ready3, credits_idle3, proto_err3;
  request_flit_t out_flit3;
  logic [3:0]    credits_out3;

  chi_link_rx_if #(.DATA_T(request_flit_t)) inf4 ();
  chi_link_rx_if #(.DATA_T(request_flit_t)) inf3 ();

  chi_link_rx #(.DATA_T(request_flit_t), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx(inf4), .link_en(link_en4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_flit(out_flit4),
    .credits_out(credits_out4), .credits_idle(credits_idle4), .proto_err(proto_err4));

  chi_link_rx #(.DATA_T(request_flit_t), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rx(inf3), .link_en(link_en3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_flit(out_flit3),
    .credits_out(credits_out3), .credits_idle(credits_idle3), .proto_err(proto_err3));

  int n_checks = 0;
  int n_fail   = 0;
  request_flit_t sb4[$];
  request_flit_t sb3[$];

  function automatic request_flit_t mk(input chi_opcode_t opc, input logic [11:0] txn);
    request_flit_t f;
    f        = '0;
    f.opcode = opc;
    f.txn_id = txn;
    f.src_id = 7'h05;
    f.addr   = {24'h0, txn, 12'h040};
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; link_en4 = 1'b1; link_en3 = 1'b1;
    out_ready4 = 1'b0; out_ready3 = 1'b0;
    inf4.flit_pend = 1'b0; inf4.flit_v = 1'b0; inf4.flit = '0;
    inf3.flit_pend = 1'b0; inf3.flit_v = 1'b0; inf3.flit = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid4); end
    n_checks++; if (inf4.lcrd_v !== 1'b0) begin n_fail++; $display("FAIL rst_lcrd_v: got %0b want 0", inf4.lcrd_v); end
    n_checks++; if (credits_out4 !== 4'd0) begin n_fail++; $display("FAIL rst_credits: got %0d want 0", credits_out4); end
    n_checks++; if (credits_idle4 !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %0b want 1", credits_idle4); end
    n_checks++; if (proto_err4 !== 1'b0) begin n_fail++; $display("FAIL rst_proto_err: got %0b want 0", proto_err4); end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_checks++; if (inf4.lcrd_v !== (k <= 4)) begin n_fail++; $display("FAIL ramp_lcrd_v cycle %0d: got %0b want %0b", k, inf4.lcrd_v, (k <= 4)); end
      n_checks++; if (credits_out4 !== 4'((k < 4) ? k : 4)) begin n_fail++; $display("FAIL ramp_credits cycle %0d: got %0d want %0d", k, credits_out4, (k < 4) ? k : 4); end
    end
  endtask

  task automatic test_fill_pop();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inf4.flit_v = 1'b1; inf4.flit = mk(READ_SHARED, 12'(12'h010 + i));
      sb4.push_back(inf4.flit);
    end
    @(negedge clk);
    inf4.flit_v = 1'b0;
    n_checks++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %0b want 1", out_valid4); end
    n_checks++; if (credits_out4 !== 4'd0) begin n_fail++; $display("FAIL fill_credits: got %0d want 0", credits_out4); end
    n_checks++; if (credits_idle4 !== 1'b1) begin n_fail++; $display("FAIL fill_idle: got %0b want 1", credits_idle4); end
    @(negedge clk);
    n_checks++; if (inf4.lcrd_v !== 1'b0) begin n_fail++; $display("FAIL fill_no_lcrd: got %0b want 0", inf4.lcrd_v); end
    out_ready4 = 1'b1;
    n_checks++; if (out_flit4 !== sb4[0]) begin n_fail++; $display("FAIL pop1_flit: got %0h want %0h", out_flit4, sb4[0]); end
    void'(sb4.pop_front());
    @(negedge clk);
    out_ready4 = 1'b0;
    n_checks++; if (inf4.lcrd_v !== 1'b0) begin n_fail++; $display("FAIL pop1_lcrd_early: got %0b want 0", inf4.lcrd_v); end
    n_checks++; if (out_flit4.txn_id !== 12'h011) begin n_fail++; $display("FAIL pop1_next_txn: got %0h want 11", out_flit4.txn_id); end
    @(negedge clk);
    n_checks++; if (inf4.lcrd_v !== 1'b1) begin n_fail++; $display("FAIL pop1_lcrd: got %0b want 1", inf4.lcrd_v); end
    n_checks++; if (credits_out4 !== 4'd1) begin n_fail++; $display("FAIL pop1_credits: got %0d want 1", credits_out4); end
    @(negedge clk);
    n_checks++; if (inf4.lcrd_v !== 1'b0) begin n_fail++; $display("FAIL pop1_lcrd_once: got %0b want 0", inf4.lcrd_v); end
    for (int c = 0; c < 20 && sb4.size() > 0; c++) begin
      @(negedge clk);
      out_ready4 = 1'b1;
      n_checks++;
      if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL drain_valid: got %0b want 1", out_valid4); end
      else begin
        if (out_flit4 !== sb4[0]) begin n_fail++; $display("FAIL drain_flit: got %0h want %0h", out_flit4, sb4[0]); end
        void'(sb4.pop_front());
      end
    end
    @(negedge clk);
    out_ready4 = 1'b0;
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %0b want 0", out_valid4); end
    for (int c = 0; c < 10 && credits_out4 != 4'd4; c++) @(negedge clk);
    n_checks++; if (credits_out4 !== 4'd4) begin n_fail++; $display("FAIL refill_credits: got %0d want 4", credits_out4); end
  endtask

  task automatic test_proto_err();
    @(negedge clk);
    link_en4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inf4.flit_v = 1'b1; inf4.flit = mk(READ_SHARED, 12'(12'h020 + i));
      sb4.push_back(inf4.flit);
      @(negedge clk);
    end
    inf4.flit = mk(READ_SHARED, 12'h099);
    @(negedge clk);
    inf4.flit_v = 1'b0;
    n_checks++; if (proto_err4 !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %0b want 1", proto_err4); end
    n_checks++; if (credits_out4 !== 4'd0) begin n_fail++; $display("FAIL perr_credits: got %0d want 0", credits_out4); end
    n_checks++; if (out_flit4 !== sb4[0]) begin n_fail++; $display("FAIL perr_head: got %0h want %0h", out_flit4, sb4[0]); end
    for (int c = 0; c < 20 && sb4.size() > 0; c++) begin
      @(negedge clk);
      out_ready4 = 1'b1;
      n_checks++;
      if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL perr_drain_valid: got %0b want 1", out_valid4); end
      else begin
        if (out_flit4 !== sb4[0]) begin n_fail++; $display("FAIL perr_drain_flit: got %0h want %0h", out_flit4, sb4[0]); end
        void'(sb4.pop_front());
      end
    end
    @(negedge clk);
    out_ready4 = 1'b0;
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL perr_dropped: got %0b want 0", out_valid4); end
    n_checks++; if (proto_err4 !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %0b want 1", proto_err4); end
  endtask

  task automatic test_link_deact();
    n_checks++; if (credits_idle4 !== 1'b1) begin n_fail++; $display("FAIL deact_idle_start: got %0b want 1", credits_idle4); end
    link_en4 = 1'b1;
    @(negedge clk);
    n_checks++; if (inf4.lcrd_v !== 1'b1) begin n_fail++; $display("FAIL deact_resume: got %0b want 1", inf4.lcrd_v); end
    for (int c = 0; c < 10 && credits_out4 != 4'd4; c++) @(negedge clk);
    n_checks++; if (credits_out4 !== 4'd4) begin n_fail++; $display("FAIL deact_credits4: got %0d want 4", credits_out4); end
    link_en4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n_checks++; if (credits_out4 !== 4'(4 - i)) begin n_fail++; $display("FAIL deact_ret_credits %0d: got %0d want %0d", i, credits_out4, 4 - i); end
      end
      inf4.flit_v = 1'b1; inf4.flit = mk(REQ_LCRD_RETURN, 12'(12'h040 + i));
      @(negedge clk);
    end
    inf4.flit_v = 1'b0;
    n_checks++; if (credits_idle4 !== 1'b1) begin n_fail++; $display("FAIL deact_idle: got %0b want 1", credits_idle4); end
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL deact_not_enqueued: got %0b want 0", out_valid4); end
    repeat (2) @(negedge clk);
    n_checks++; if (inf4.lcrd_v !== 1'b0) begin n_fail++; $display("FAIL deact_no_grant: got %0b want 0", inf4.lcrd_v); end
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL deact_still_empty: got %0b want 0", out_valid4); end
  endtask

  task automatic test_back_to_back_wrap();
    int tx_cred;
    int sent;
    tx_cred = 3;
    n_checks++; if (credits_out3 !== 4'd3) begin n_fail++; $display("FAIL wrap_start_credits: got %0d want 3", credits_out3); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      inf3.flit_v = 1'b1; inf3.flit = mk(READ_UNIQUE, 12'(12'h300 + i));
      sb3.push_back(inf3.flit);
      tx_cred--;
    end
    sent = 2;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      tx_cred += int'(inf3.lcrd_v);
      n_checks++; if (credits_out3 !== 4'(tx_cred)) begin n_fail++; $display("FAIL wrap_credits cycle %0d: got %0d want %0d", c, credits_out3, tx_cred); end
      if (sb3.size() > 0) begin
        out_ready3 = 1'b1;
        n_checks++;
        if (out_valid3 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid cycle %0d: got %0b want 1", c, out_valid3); end
        else begin
          if (out_flit3 !== sb3[0]) begin n_fail++; $display("FAIL wrap_order cycle %0d: got %0h want %0h", c, out_flit3, sb3[0]); end
          void'(sb3.pop_front());
        end
      end else out_ready3 = 1'b0;
      if (tx_cred > 0 && sent < 14) begin
        inf3.flit_v = 1'b1; inf3.flit = mk(READ_UNIQUE, 12'(12'h300 + sent));
        sb3.push_back(inf3.flit);
        tx_cred--; sent++;
      end else inf3.flit_v = 1'b0;
    end
    out_ready3 = 1'b0;
    n_checks++; if (sb3.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d entries want 0", sb3.size()); end
    n_checks++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %0b want 0", out_valid3); end
    n_checks++; if (proto_err3 !== 1'b0) begin n_fail++; $display("FAIL wrap_proto_err: got %0b want 0", proto_err3); end
  endtask

  task automatic test_reset_mid();
    link_en4 = 1'b1;
    for (int c = 0; c < 10 && credits_out4 != 4'd4; c++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      inf4.flit_v = 1'b1; inf4.flit = mk(READ_SHARED, 12'(12'h050 + i));
      @(negedge clk);
    end
    inf4.flit_v = 1'b0;
    n_checks++; if (credits_out4 !== 4'd1) begin n_fail++; $display("FAIL mid_credits: got %0d want 1", credits_out4); end
    n_checks++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %0b want 1", out_valid4); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid4); end
    n_checks++; if (inf4.lcrd_v !== 1'b0) begin n_fail++; $display("FAIL mid_rst_lcrd: got %0b want 0", inf4.lcrd_v); end
    n_checks++; if (credits_out4 !== 4'd0) begin n_fail++; $display("FAIL mid_rst_credits: got %0d want 0", credits_out4); end
    n_checks++; if (proto_err4 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_proto_err: got %0b want 0", proto_err4); end
    sb4.delete();
    test_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_fill_pop();
    test_proto_err();
    test_link_deact();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
